fft_8_frame_loader: RTL
=======================

Name: fft_8_frame_loader

Overview:
- Upstream feeder for the 8-point FFT core (fft_8_sol2_gen2).
- Accepts a serial valid/ready stream of complex 16-bit samples and assembles 8-sample frames in a ping-pong buffer.
- Presents a full frame as flat parallel buses to the FFT, pulses its start, and holds the frame until the FFT reports done.
- Fills the second bank while the FFT works on the first, so input streaming does not stall across frames.

Parameters:
- DW, 16, sample component width (real and imag each).
- BITREV, 0, 1 = write sample k into slot bitrev3(k); 0 = natural order.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous, active-low reset.
- in_valid  input  1  input sample valid.
- in_ready  output  1  loader can accept a sample.
- in_real  input  DW  sample real part, two's complement.
- in_imag  input  DW  sample imaginary part, two's complement.
- in_last  input  1  marks the final sample of a frame.
- fft_start  output  1  one-cycle start pulse to the FFT.
- fft_done  input  1  FFT done, level; sampled synchronously.
- frame_real  output  8*DW  slot k at bits [DW*k+DW-1 : DW*k].
- frame_imag  output  8*DW  same packing as frame_real.
- frame_count  output  16  frames issued to the FFT; wraps at 65535.
- sync_err  output  8  frame-alignment errors; saturates at 255.

Behaviour:
- Reset (rst low, asynchronous): both banks empty, wr_bank=0, rd_bank=0, wr_idx=0, issuer IDLE. fft_start=0, frame_real/imag=0, frame_count=0, sync_err=0. in_ready=1 once reset is released.
- Storage: two banks of 8 complex registers, with full[1:0] flags.
- Write side:
  - in_ready = !full[wr_bank] (combinational).
  - A transfer occurs when in_valid && in_ready. The sample is written to slot wr_idx, or bitrev3(wr_idx) when BITREV=1, of wr_bank, and wr_idx increments.
  - On the transfer with wr_idx==7: set full[wr_bank], toggle wr_bank, wr_idx=0. This happens regardless of in_last.
  - in_last on a transfer with wr_idx<7: the partial frame is discarded, wr_idx=0, sync_err increments (saturating), and no bank is marked full. The in_last sample itself is dropped.
  - in_valid while in_ready=0: no effect; the source must hold its data.
- Issue FSM, states IDLE, START, WAIT:
  - IDLE: if full[rd_bank], go to START.
  - START: fft_start=1 for exactly this cycle; frame_count increments; go to WAIT. fft_done is ignored in this cycle.
  - WAIT: on the first cycle fft_done==1, clear full[rd_bank], toggle rd_bank, go to IDLE.
- frame_real/imag:
  - Registered copy of bank rd_bank, loaded on the IDLE->START transition.
  - Stable from the START cycle until new contents are loaded; unchanged while in WAIT.
- Latency: the edge accepting sample 7 is edge N. With the issuer IDLE, fft_start is high in the cycle following edge N+1, and the frame buses are valid in that same cycle.
- Back-to-back operation:
  - The writer fills the opposite bank during WAIT.
  - If both banks are full, in_ready=0 until fft_done frees rd_bank.
  - The freed bank becomes writable in the cycle after done is observed.
- Simultaneous events:
  - Setting full[wr_bank] and clearing full[rd_bank] in the same cycle is legal, because the banks are distinct by construction.
  - If the clear and a frame completion coincide, the completed frame is issued next without loss.
- fft_done high while in IDLE or START: ignored.
- Reset mid-frame or mid-WAIT: all state is discarded, the partial frame is lost, and no fft_start is produced after reset.

Test Plan:
- Reset, then stream samples 0x0001..0x0008 (imag 0x0000) with in_valid continuous -> single fft_start pulse 2 edges after the 8th accept; frame_real=0x0008_0007_..._0001 (slot0=0x0001); frame_count=1; done pulse returns FSM to IDLE.
- BITREV=1, same stream -> slots 0..7 hold 1,5,3,7,2,6,4,8.
- Stream 24 samples continuously while holding fft_done low -> in_ready drops after sample 16; asserting fft_done for 1 cycle -> in_ready rises next cycle, second frame (9..16) issued, samples 17..24 accepted; frame_count=2.
- in_last on the 5th sample, then 8 samples 0x0100..0x0107 -> sync_err=1, no start for the partial frame, next frame slot0=0x0100.
- Assert rst low mid-WAIT with the second bank half full -> all outputs 0, in_ready=1 after release, no spurious fft_start; fft_done held high during IDLE produces no action.

Source files
------------

// File: rtl/fft_8_frame_loader.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module   : fft_8_frame_loader
// Purpose  : Assembles a serial valid/ready stream of complex samples into
//            8-sample frames held in a ping-pong register buffer. Each full
//            frame is presented on flat parallel buses to the 8-point FFT
//            core, which is kicked with a one-cycle start pulse. The frame is
//            held until the core reports done. The opposite bank keeps
//            filling meanwhile.
// Ports    : clk         - system clock, rising edge
//            rst         - asynchronous reset, active low
//            in_valid    - input sample valid
//            in_ready    - loader can accept a sample
//            in_real     - sample real part, two's complement
//            in_imag     - sample imaginary part, two's complement
//            in_last     - final sample of a frame
//            fft_start   - one-cycle start pulse to the FFT
//            fft_done    - FFT done level, sampled synchronously
//            frame_real  - slot k at [DW*k +: DW]
//            frame_imag  - same packing as frame_real
//            frame_count - frames issued, wraps
//            sync_err    - frame-alignment errors, saturating
// Revision : 1.0 - initial release
// ============================================================================
module fft_8_frame_loader #(
  parameter int DW     = 16,
  parameter bit BITREV = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DW-1:0]   in_real,
  input  logic [DW-1:0]   in_imag,
  input  logic            in_last,
  output logic            fft_start,
  input  logic            fft_done,
  output logic [8*DW-1:0] frame_real,
  output logic [8*DW-1:0] frame_imag,
  output logic [15:0]     frame_count,
  output logic [7:0]      sync_err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  // Sample storage: [bank][slot]
  logic [DW-1:0]   bank_re_q [2][8];
  logic [DW-1:0]   bank_im_q [2][8];

  logic [1:0]      full_q, full_d;
  logic            wr_bank_q;
  logic            rd_bank_q;
  logic [2:0]      wr_idx_q;
  state_t          state_q;
  logic            fft_start_q;
  logic [8*DW-1:0] frame_real_q, frame_imag_q;
  logic [15:0]     frame_count_q;
  logic [7:0]      sync_err_q;

  logic            w_accept;
  logic            w_complete;
  logic            w_abort;
  logic            w_release;
  logic [2:0]      w_slot;
  logic [8*DW-1:0] w_rd_re, w_rd_im;

  assign in_ready   = !full_q[wr_bank_q];
  assign w_accept   = in_valid && in_ready;
  // The 8th sample always closes the frame, whether or not in_last is set.
  assign w_complete = w_accept && (wr_idx_q == 3'd7);
  assign w_abort    = w_accept && in_last && (wr_idx_q != 3'd7);
  assign w_release  = (state_q == S_WAIT) && fft_done;
  assign w_slot     = BITREV ? {wr_idx_q[0], wr_idx_q[1], wr_idx_q[2]} : wr_idx_q;

  // Set and clear can coincide; they always hit different banks because a
  // bank being written is never full while the bank in WAIT always is.
  always_comb begin
    full_d = full_q;
    if (w_release) full_d[rd_bank_q] = 1'b0;
    if (w_complete) full_d[wr_bank_q] = 1'b1;
  end

  // Flatten the bank being read so it can be captured in one edge.
  always_comb begin
    w_rd_re = '0;
    w_rd_im = '0;
    for (int k = 0; k < 8; k++) begin
      w_rd_re[DW*k +: DW] = bank_re_q[rd_bank_q][k];
      w_rd_im[DW*k +: DW] = bank_im_q[rd_bank_q][k];
    end
  end

  // Sample data needs no reset: slots are only read once the full flag,
  // which is reset, says all eight have been written.
  always_ff @(posedge clk) begin
    if (w_accept && !w_abort) begin
      bank_re_q[wr_bank_q][w_slot] <= in_real;
      bank_im_q[wr_bank_q][w_slot] <= in_imag;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full_q        <= 2'b00;
      wr_bank_q     <= 1'b0;
      rd_bank_q     <= 1'b0;
      wr_idx_q      <= 3'd0;
      sync_err_q    <= 8'd0;
      state_q       <= S_IDLE;
      fft_start_q   <= 1'b0;
      frame_real_q  <= '0;
      frame_imag_q  <= '0;
      frame_count_q <= 16'd0;
    end else begin
      full_q <= full_d;

      // Write side
      if (w_complete) begin
        wr_idx_q  <= 3'd0;
        wr_bank_q <= ~wr_bank_q;
      end else if (w_abort) begin
        // Early in_last: drop the partial frame and the marker sample.
        wr_idx_q <= 3'd0;
        if (sync_err_q != 8'hFF) sync_err_q <= sync_err_q + 8'd1;
      end else if (w_accept) begin
        wr_idx_q <= wr_idx_q + 3'd1;
      end

      // Issue FSM
      case (state_q)
        S_IDLE: begin
          fft_start_q <= 1'b0;
          if (full_q[rd_bank_q]) begin
            state_q      <= S_START;
            fft_start_q  <= 1'b1;
            frame_real_q <= w_rd_re;
            frame_imag_q <= w_rd_im;
          end
        end
        S_START: begin
          fft_start_q   <= 1'b0;
          frame_count_q <= frame_count_q + 16'd1;
          state_q       <= S_WAIT;
        end
        S_WAIT: begin
          fft_start_q <= 1'b0;
          if (fft_done) begin
            rd_bank_q <= ~rd_bank_q;
            state_q   <= S_IDLE;
          end
        end
        default: begin
          fft_start_q <= 1'b0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign fft_start   = fft_start_q;
  assign frame_real  = frame_real_q;
  assign frame_imag  = frame_imag_q;
  assign frame_count = frame_count_q;
  assign sync_err    = sync_err_q;

endmodule
`default_nettype wire
